// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory / IO block between the
// CPU load/store path (port 0) and the debug/DMA loader (port 1).
// Round-robin with a burst limit; one access per cycle; reads return one
// cycle after their grant and are routed back to the requesting port.
//
// state | meaning
// IDLE  | no owner, nothing granted last cycle
// OWN0  | port 0 received the most recent grant
// OWN1  | port 1 received the most recent grant
module dmem_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam int              CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0]   BURST_ONE = CW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] burst_nxt;
  logic          burst_full;
  logic          last_owner;
  logic          rd_pend;
  logic          rd_tag;
  logic          sel0;
  logic          sel1;
  logic          cont;
  logic [DW-1:0] hold0;
  logic [DW-1:0] hold1;

  assign burst_full = (burst_cnt >= BURST_MAX);

  // Arbitration decision and next ownership / burst count.
  always_comb begin
    sel0      = 1'b0;
    sel1      = 1'b0;
    cont      = 1'b0;
    burst_nxt = '0;
    unique case (state)
      OWN0: begin
        if (r0_req && (!burst_full || !r1_req)) begin
          sel0 = 1'b1;
          cont = 1'b1;
        end else if (r1_req) begin
          sel1 = 1'b1;
        end
      end
      OWN1: begin
        if (r1_req && (!burst_full || !r0_req)) begin
          sel1 = 1'b1;
          cont = 1'b1;
        end else if (r0_req) begin
          sel0 = 1'b1;
        end
      end
      default: begin
        if (r0_req && r1_req) begin
          sel0 = last_owner;
          sel1 = !last_owner;
        end else begin
          sel0 = r0_req;
          sel1 = r1_req;
        end
      end
    endcase
    if (cont)
      burst_nxt = burst_full ? burst_cnt : burst_cnt + BURST_ONE;
    else if (sel0 || sel1)
      burst_nxt = BURST_ONE;
    state_nxt = sel0 ? OWN0 : (sel1 ? OWN1 : IDLE);
  end

  // Grants are suppressed while reset is held so nothing reaches the LSU.
  assign r0_gnt = sel0 & rst;
  assign r1_gnt = sel1 & rst;

  assign mem_addr  = r0_gnt ? r0_addr  : (r1_gnt ? r1_addr  : '0);
  assign mem_wdata = r0_gnt ? r0_wdata : (r1_gnt ? r1_wdata : '0);
  assign mem_wren  = (r0_gnt & r0_we) | (r1_gnt & r1_we);

  // LSU read data is already registered, so it is steered through directly
  // in the return cycle and captured to hold the value afterwards.
  assign r0_rvalid = rd_pend & !rd_tag;
  assign r1_rvalid = rd_pend & rd_tag;
  assign r0_rdata  = r0_rvalid ? mem_rdata : hold0;
  assign r1_rdata  = r1_rvalid ? mem_rdata : hold1;

  // Ownership, burst tracking and read-return bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (r0_gnt || r1_gnt)
        last_owner <= r1_gnt;
      rd_pend <= (r0_gnt & !r0_we) | (r1_gnt & !r1_we);
      rd_tag  <= r1_gnt;
    end
  end

  // Hold the last returned read data per port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (r0_rvalid)
        hold0 <= mem_rdata;
      if (r1_rvalid)
        hold1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run
// checked every cycle against a request-level reference model.
module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;

  int checks;
  int failures;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LSU stand-in: registered read, one-cycle latency.
  logic [DW-1:0] lsu_mem [0:2047];
  always @(posedge clk) begin
    if (mem_wren)
      lsu_mem[mem_addr] <= mem_wdata;
    mem_rdata <= lsu_mem[mem_addr];
  end

  // Reference model: who was served last, how many times in a row, and the
  // read that is due back next cycle.
  logic [DW-1:0] ref_mem [0:2047];
  int            m_owner;
  int            m_streak;
  int            m_last;
  bit            m_pv;
  int            m_pp;
  logic [DW-1:0] m_pd;
  logic [DW-1:0] m_hold [2];
  int            m_lastg;

  task automatic model_reset();
    m_owner = -1; m_streak = 0; m_last = 1; m_pv = 0; m_pp = 0; m_pd = '0;
    m_hold[0] = '0; m_hold[1] = '0; m_lastg = -1;
  endtask

  // Who should be served given the current requests (-1 = nobody).
  function automatic int model_pick(bit q0, bit q1);
    if (!q0 && !q1) return -1;
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (m_owner < 0) return (m_last == 1) ? 0 : 1;
    if (m_streak < MAXB) return m_owner;
    return 1 - m_owner;
  endfunction

  function automatic int exp_grant();
    return rst ? model_pick(r0_req, r1_req) : -1;
  endfunction

  // Advance one clock: model consumes the inputs seen at the rising edge.
  task automatic tick();
    int g;
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      g = model_pick(r0_req, r1_req);
      if (m_pv) m_hold[m_pp] = m_pd;
      m_pv = 0;
      if (g >= 0) begin
        we = (g == 0) ? r0_we : r1_we;
        a  = (g == 0) ? r0_addr : r1_addr;
        d  = (g == 0) ? r0_wdata : r1_wdata;
        if (we) ref_mem[a] = d;
        else begin m_pv = 1; m_pp = g; m_pd = ref_mem[a]; end
        m_streak = (g == m_owner) ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 1;
        m_owner = g;
        m_last = g;
      end else begin
        m_owner = -1;
        m_streak = 0;
      end
      m_lastg = g;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int p, input bit q, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p == 0) begin r0_req = q; r0_we = w; r0_addr = a; r0_wdata = d; end
    else        begin r1_req = q; r1_we = w; r1_addr = a; r1_wdata = d; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 1, 1, 11'h123, 32'h1111_1111);
    drive(1, 1, 1, 11'h456, 32'h2222_2222);
    model_reset();
    @(negedge clk); #1;
    checks++;
    if ({r0_gnt, r1_gnt, mem_wren, r0_rvalid, r1_rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {r0_gnt, r1_gnt, mem_wren, r0_rvalid, r1_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata, r0_rdata, r1_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h rd0=%h rd1=%h exp all 0", mem_addr, mem_wdata, r0_rdata, r1_rdata);
    end
    tick();
    rst = 1'b1; #1;
    checks++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_gnt got=%b exp=10", {r0_gnt, r1_gnt});
    end
    tick();
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    tick();
  endtask

  task automatic preload();
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 1, (i == 16) ? 11'd1280 : 11'(i * 16), $urandom);
      #1;
      checks++;
      if ({r1_gnt, mem_wren, mem_addr} !== {2'b11, r1_addr}) begin
        failures++;
        $display("FAIL preload_write got=%b%b %h exp=11 %h", r1_gnt, mem_wren, mem_addr, r1_addr);
      end
      tick();
    end
    drive(1, 0, 0, '0, '0);
    tick();
  endtask

  task automatic test_write_read();
    drive(0, 1, 1, 11'h490, 32'hDEAD_BEEF); #1;
    checks++;
    if ({r0_gnt, r1_gnt, mem_wren, mem_addr, mem_wdata} !== {3'b101, 11'h490, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL wr_drive got gnt0=%b gnt1=%b wren=%b addr=%h wd=%h exp 1 0 1 490 deadbeef",
               r0_gnt, r1_gnt, mem_wren, mem_addr, mem_wdata);
    end
    tick();
    drive(0, 1, 0, 11'h490, '0); #1;
    checks++;
    if ({r0_gnt, mem_wren, mem_addr} !== {2'b10, 11'h490}) begin
      failures++;
      $display("FAIL rd_drive got gnt0=%b wren=%b addr=%h exp 1 0 490", r0_gnt, mem_wren, mem_addr);
    end
    tick();
    drive(0, 0, 0, '0, '0); #1;
    checks++;
    if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL rd_return got v0=%b v1=%b d0=%h exp 1 0 deadbeef", r0_rvalid, r1_rvalid, r0_rdata);
    end
    tick(); #1;
    checks++;
    if ({r0_rvalid, r0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL rd_hold got v0=%b d0=%h exp 0 deadbeef", r0_rvalid, r0_rdata);
    end
  endtask

  task automatic test_burst();
    // One lone port-1 grant so port 1 is the last owner going in.
    drive(1, 1, 1, 11'h7F0, 32'h0); tick();
    drive(1, 0, 0, '0, '0); tick();
    drive(0, 1, 0, 11'h000, '0);
    drive(1, 1, 0, 11'h010, '0);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] exp_g;
      exp_g = (((i / MAXB) % 2) == 0) ? 2'b10 : 2'b01;
      #1;
      checks++;
      if ({r0_gnt, r1_gnt} !== exp_g) begin
        failures++;
        $display("FAIL burst_pattern cycle=%0d got=%b exp=%b", i, {r0_gnt, r1_gnt}, exp_g);
      end
      tick();
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    tick();
  endtask

  task automatic test_single_r1();
    int ok;
    ok = 0;
    drive(1, 1, 0, 11'h020, '0);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (r1_gnt === 1'b1 && r0_gnt === 1'b0) ok++;
      tick();
    end
    checks++;
    if (ok != 10) begin
      failures++;
      $display("FAIL single_r1_grants got=%0d exp=10", ok);
    end
    // Port 1's run is at the limit, so a new port-0 request wins at once.
    drive(0, 1, 0, 11'h030, '0); #1;
    checks++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL single_r1_saturate got=%b exp=10", {r0_gnt, r1_gnt});
    end
    tick();
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    tick();
  endtask

  task automatic test_interleave();
    drive(0, 1, 0, 11'h010, '0); tick();
    drive(0, 0, 0, '0, '0);
    drive(1, 1, 0, 11'h020, '0); #1;
    checks++;
    if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b10, ref_mem[11'h010]}) begin
      failures++;
      $display("FAIL interleave_r0 got v0=%b v1=%b d0=%h exp 1 0 %h", r0_rvalid, r1_rvalid, r0_rdata, ref_mem[11'h010]);
    end
    tick();
    drive(1, 0, 0, '0, '0); #1;
    checks++;
    if ({r0_rvalid, r1_rvalid, r1_rdata} !== {2'b01, ref_mem[11'h020]}) begin
      failures++;
      $display("FAIL interleave_r1 got v0=%b v1=%b d1=%h exp 0 1 %h", r0_rvalid, r1_rvalid, r1_rdata, ref_mem[11'h020]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 0, 11'h030, '0); tick();
    drive(0, 0, 0, '0, '0);
    rst = 1'b0;
    model_reset(); #1;
    checks++;
    if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b00, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid_during got v0=%b v1=%b d0=%h exp 0 0 0", r0_rvalid, r1_rvalid, r0_rdata);
    end
    tick();
    rst = 1'b1; #1;
    checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_release got=%b exp=00", {r0_rvalid, r1_rvalid});
    end
    tick(); #1;
    checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_after got=%b exp=00", {r0_rvalid, r1_rvalid});
    end
  endtask

  task automatic test_random();
    bit            pend [2];
    bit            pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    int            eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ew;
    logic [DW-1:0] er0, er1;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom % 4) != 0) begin
          pend[p] = 1;
          pw[p] = ($urandom % 2) == 1;
          pa[p] = (($urandom % 8) == 0) ? 11'd1280 : 11'(($urandom % 16) * 16);
          pd[p] = $urandom;
        end else if (pend[p] && ($urandom % 16) == 0) begin
          pend[p] = 0;
        end
        drive(p, pend[p], pw[p], pa[p], pd[p]);
      end
      #1;
      eg = exp_grant();
      ew = (eg == 0) ? r0_we : ((eg == 1) ? r1_we : 1'b0);
      ea = (eg == 0) ? r0_addr : ((eg == 1) ? r1_addr : '0);
      ed = (eg == 0) ? r0_wdata : ((eg == 1) ? r1_wdata : '0);
      er0 = (m_pv && m_pp == 0) ? m_pd : m_hold[0];
      er1 = (m_pv && m_pp == 1) ? m_pd : m_hold[1];
      checks++;
      if ({r0_gnt, r1_gnt} !== {eg == 0, eg == 1}) begin
        failures++;
        $display("FAIL rand_gnt cycle=%0d got=%b%b exp_port=%0d", c, r0_gnt, r1_gnt, eg);
      end
      checks++;
      if ({mem_wren, mem_addr, mem_wdata} !== {ew, ea, ed}) begin
        failures++;
        $display("FAIL rand_mem cycle=%0d got %b %h %h exp %b %h %h", c, mem_wren, mem_addr, mem_wdata, ew, ea, ed);
      end
      checks++;
      if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !== {m_pv && m_pp == 0, m_pv && m_pp == 1, er0, er1}) begin
        failures++;
        $display("FAIL rand_rdata cycle=%0d got v=%b%b d0=%h d1=%h exp v=%b%b d0=%h d1=%h", c,
                 r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, m_pv && m_pp == 0, m_pv && m_pp == 1, er0, er1);
      end
      tick();
      if (m_lastg >= 0) pend[m_lastg] = 0;
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    model_reset();
    test_reset();
    preload();
    test_write_read();
    test_burst();
    test_single_r1();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
